// File: rtl/speed_lim_mem_arbiter_if.sv
// Bus bundle for the speed-limit memory arbiter: lookup port, config port and
// the single-port memory it owns. The slave modport is the arbiter side.
interface speed_lim_mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7
);
  logic              init_done;
  logic              lk_req_valid;
  logic              lk_req_ready;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_rsp_valid;
  logic [DATA_W-1:0] lk_rsp_data;
  logic              cfg_req_valid;
  logic              cfg_req_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_rsp_valid;
  logic [DATA_W-1:0] cfg_rsp_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    output init_done,
    input  lk_req_valid, lk_addr,
    output lk_req_ready, lk_rsp_valid, lk_rsp_data,
    input  cfg_req_valid, cfg_we, cfg_addr, cfg_wdata,
    output cfg_req_ready, cfg_rsp_valid, cfg_rsp_data,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    input  init_done,
    output lk_req_valid, lk_addr,
    input  lk_req_ready, lk_rsp_valid, lk_rsp_data,
    output cfg_req_valid, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_req_ready, cfg_rsp_valid, cfg_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/speed_lim_mem_arbiter.sv
// Owns the single-port speed-limit table: init sweep after reset, then one
// access per cycle with lookup priority and a starvation guard for config.
module speed_lim_mem_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 7,
  parameter int INIT_LIMIT = 40,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  speed_lim_mem_arbiter_if.slave  bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] init_addr_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              tag_valid_r;
  logic              tag_cfg_r;
  logic              tag_write_r;
  logic [DATA_W-1:0] tag_wdata_r;
  logic              init_done_r;
  logic [DATA_W-1:0] lk_data_r;
  logic [DATA_W-1:0] cfg_data_r;

  logic              run_s, init_s, urgent_s;
  logic              lk_ready_s, cfg_ready_s, lk_acc_s, cfg_acc_s;
  logic              lk_rsp_s, cfg_rsp_s;
  logic [DATA_W-1:0] lk_rsp_data_s, cfg_rsp_data_s;

  // Arbitration, response steering; rst masks everything so outputs read 0 in reset
  always_comb begin
    run_s       = (state_r == ST_RUN) && !rst;
    init_s      = (state_r == ST_INIT) && !rst;
    urgent_s    = (wait_cnt_r >= WAIT_W'(MAX_WAIT));
    lk_ready_s  = run_s && !(urgent_s && bus.cfg_req_valid);
    cfg_ready_s = run_s && (!bus.lk_req_valid || urgent_s);
    lk_acc_s    = bus.lk_req_valid && lk_ready_s;
    cfg_acc_s   = bus.cfg_req_valid && cfg_ready_s && !lk_acc_s;
    lk_rsp_s    = tag_valid_r && !tag_cfg_r && !rst;
    cfg_rsp_s   = tag_valid_r && tag_cfg_r && !rst;
    lk_rsp_data_s  = lk_data_r;
    cfg_rsp_data_s = cfg_data_r;
    if (rst) begin
      lk_rsp_data_s  = {DATA_W{1'b0}};
      cfg_rsp_data_s = {DATA_W{1'b0}};
    end else begin
      if (lk_rsp_s) begin
        lk_rsp_data_s = bus.mem_dout;
      end else begin
        lk_rsp_data_s = lk_data_r;
      end
      if (cfg_rsp_s) begin
        cfg_rsp_data_s = tag_write_r ? tag_wdata_r : bus.mem_dout;
      end else begin
        cfg_rsp_data_s = cfg_data_r;
      end
    end
  end

  // Memory port mux: init sweep, else the accepted requester, else idle
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = {ADDR_W{1'b0}};
    bus.mem_din  = {DATA_W{1'b0}};
    if (init_s) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_addr = init_addr_r;
      bus.mem_din  = DATA_W'(INIT_LIMIT);
    end else if (lk_acc_s) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.lk_addr;
    end else if (cfg_acc_s) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = bus.cfg_we;
      bus.mem_addr = bus.cfg_addr;
      bus.mem_din  = bus.cfg_wdata;
    end else begin
      bus.mem_en   = 1'b0;
    end
  end

  assign bus.init_done     = init_done_r;
  assign bus.lk_req_ready  = lk_ready_s;
  assign bus.cfg_req_ready = cfg_ready_s;
  assign bus.lk_rsp_valid  = lk_rsp_s;
  assign bus.lk_rsp_data   = lk_rsp_data_s;
  assign bus.cfg_rsp_valid = cfg_rsp_s;
  assign bus.cfg_rsp_data  = cfg_rsp_data_s;

  // Sequencer, starvation counter, in-flight tag and held response data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      init_addr_r <= {ADDR_W{1'b0}};
      wait_cnt_r  <= {WAIT_W{1'b0}};
      tag_valid_r <= 1'b0;
      tag_cfg_r   <= 1'b0;
      tag_write_r <= 1'b0;
      tag_wdata_r <= {DATA_W{1'b0}};
      init_done_r <= 1'b0;
      lk_data_r   <= {DATA_W{1'b0}};
      cfg_data_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          init_addr_r <= init_addr_r + ADDR_W'(1);
          if (init_addr_r == LAST_ADDR) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase

      if (run_s) begin
        if (!bus.cfg_req_valid || cfg_acc_s) begin
          wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (!cfg_ready_s && (wait_cnt_r < WAIT_W'(MAX_WAIT))) begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
      end

      tag_valid_r <= lk_acc_s || cfg_acc_s;
      tag_cfg_r   <= cfg_acc_s;
      tag_write_r <= cfg_acc_s && bus.cfg_we;
      tag_wdata_r <= bus.cfg_wdata;
      lk_data_r   <= lk_rsp_data_s;
      cfg_data_r  <= cfg_rsp_data_s;
    end
  end
endmodule
